// File: rtl/router_pkt_src.sv
// Upstream packet source for the 1x3 router: buffers a commanded payload and
// emits header, payload and parity bytes while honouring the router busy stall.
module router_pkt_src #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned MAX_LEN    = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_len,
    input  logic [1:0] cmd_addr,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_in,
    output logic       done,
    output logic       rej,
    output logic [7:0] parity_out
);

    localparam int unsigned LEN_W  = 6;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned GAP_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   acc;
    logic [LEN_W-1:0]    wr_idx;
    logic [LEN_W-1:0]    rd_idx;
    logic [GAP_W-1:0]    gap_cnt;
    logic [DATA_W-1:0]   pbuf [MAX_LEN];

    logic                wr_en_c;
    logic                cmd_take_c;
    logic                cmd_bad_c;
    logic                last_wr_c;
    logic                last_rd_c;
    logic                gap_end_c;

    always_comb begin
        wr_en_c    = (state == ST_LOAD) && s_valid && s_ready;
        cmd_take_c = (state == ST_IDLE) && cmd_valid && cmd_ready;
        cmd_bad_c  = (cmd_len == LEN_W'(0)) || (cmd_addr == ADDR_W'(3));
        last_wr_c  = (wr_idx == LEN_W'(len_q - LEN_W'(1)));
        last_rd_c  = (rd_idx == len_q);
        gap_end_c  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    end

    // Payload storage; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            pbuf[wr_idx] <= s_data;
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            acc        <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            gap_cnt    <= '0;
            cmd_ready  <= 1'b0;
            s_ready    <= 1'b0;
            pkt_valid  <= 1'b0;
            data_in    <= '0;
            done       <= 1'b0;
            rej        <= 1'b0;
            parity_out <= '0;
        end else begin
            done <= 1'b0;
            rej  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_take_c) begin
                        len_q  <= cmd_len;
                        addr_q <= cmd_addr;
                        if (cmd_bad_c) begin
                            rej <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            cmd_ready <= 1'b0;
                            s_ready   <= 1'b1;
                            acc       <= {cmd_len, cmd_addr};
                            wr_idx    <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_en_c) begin
                        wr_idx <= LEN_W'(wr_idx + LEN_W'(1));
                        acc    <= acc ^ s_data;
                        if (last_wr_c) begin
                            state     <= ST_HEADER;
                            s_ready   <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_in   <= {len_q, addr_q};
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        state   <= ST_PAYLOAD;
                        data_in <= pbuf[0];
                        rd_idx  <= LEN_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    // rd_idx points at the byte after the one on data_in.
                    if (!busy) begin
                        if (last_rd_c) begin
                            state      <= ST_PARITY;
                            pkt_valid  <= 1'b0;
                            data_in    <= acc;
                            parity_out <= acc;
                        end else begin
                            data_in <= pbuf[rd_idx];
                            rd_idx  <= LEN_W'(rd_idx + LEN_W'(1));
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        state   <= ST_GAP;
                        data_in <= '0;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_end_c) begin
                        state     <= ST_IDLE;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else begin
                        gap_cnt <= GAP_W'(gap_cnt + GAP_W'(1));
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    s_ready   <= 1'b0;
                    pkt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: random payloads and stalls checked against a
// byte-stream model of the packet format.
module tb_router_pkt_src;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [5:0] cmd_len = '0;
    logic [1:0] cmd_addr = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       done;
    logic       rej;
    logic [7:0] parity_out;

    router_pkt_src dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_addr(cmd_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .busy(busy), .pkt_valid(pkt_valid), .data_in(data_in),
        .done(done), .rej(rej), .parity_out(parity_out)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] pay   [0:62];
    logic [7:0] exp_b [0:63];

    // q_next asks the driver to raise the next command as soon as parity shows.
    logic q_next = 1'b0;
    int   q_len = 0;
    int   q_addr = 0;

    // Monitor: records consumed router bytes, parity bytes and event counts.
    logic [7:0] obs     [0:4095];
    logic [7:0] par_obs [0:255];
    int obs_n = 0, par_n = 0, cyc = 0, pv_cnt = 0, done_cnt = 0, rej_cnt = 0;
    int sr_cnt = 0, hold_err = 0, par_cyc = 0, done_cyc = 0, last_gap = -1;
    logic prev_pv = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (!resetn) begin
            prev_pv   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (pkt_valid && !busy && obs_n < 4096) begin
                obs[obs_n] = data_in;
                obs_n = obs_n + 1;
            end
            if (pkt_valid) begin
                pv_cnt = pv_cnt + 1;
                if (!prev_pv && par_n > 0) last_gap = cyc - par_cyc - 1;
            end
            if (!pkt_valid && prev_pv && par_n < 256) begin
                par_obs[par_n] = data_in;
                par_n   = par_n + 1;
                par_cyc = cyc;
            end
            if (prev_busy && prev_pv && (pkt_valid !== 1'b1 || data_in !== prev_data))
                hold_err = hold_err + 1;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (rej) rej_cnt = rej_cnt + 1;
            if (s_ready) sr_cnt = sr_cnt + 1;
            prev_pv   = pkt_valid;
            prev_busy = busy;
            prev_data = data_in;
        end
    end

    // Reference stream: header = len*4+addr, payload as given, parity = XOR of all.
    task automatic build_model(input int len, input int addr, output logic [7:0] par);
        exp_b[0] = 8'(len * 4 + addr);
        par = exp_b[0];
        for (int i = 0; i < len; i++) begin
            exp_b[i+1] = pay[i];
            par = par ^ pay[i];
        end
    endtask

    task automatic fill_payload(input int len);
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
    endtask

    // mode: 0 no busy, 1 three-cycle stall on payload byte 5, 2 random busy,
    // 3 assert reset while payload byte 7 is on data_in.
    task automatic drive_packet(input int len, input int addr, input int mode);
        int t, i, cons, stall;
        logic ok, consumed, used;
        cmd_valid = 1'b1;
        cmd_len   = 6'(len);
        cmd_addr  = 2'(addr);
        t = 0; ok = 1'b0;
        while (!ok && t < 2000) begin
            ok = cmd_ready;
            @(posedge clock); #1;
            t++;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed %b, required 1", cmd_ready);
            return;
        end
        if (len == 0 || addr == 3) return;
        i = 0; t = 0;
        while (i < len && t < 5000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = pay[i];
            ok = s_valid && s_ready;
            @(posedge clock); #1;
            if (ok) i++;
            t++;
        end
        s_valid = 1'b0;
        if (i < len) begin
            checks++; errors++;
            $display("FAIL load_timeout: loaded %0d bytes, required %0d", i, len);
            return;
        end
        cons = 0; stall = 0; used = 1'b0; t = 0;
        while (done !== 1'b1 && t < 2000) begin
            if (mode == 3 && pkt_valid && cons == 8) begin
                resetn = 1'b0;
                busy   = 1'b0;
                return;
            end
            if (q_next && !pkt_valid && cons > 0) begin
                cmd_valid = 1'b1;
                cmd_len   = 6'(q_len);
                cmd_addr  = 2'(q_addr);
            end
            if (mode == 1 && !used && pkt_valid && cons == 6) begin
                stall = 3;
                used  = 1'b1;
            end
            if (mode == 1) busy = (stall > 0);
            else if (mode == 2) busy = ($urandom_range(0, 2) == 0);
            else busy = 1'b0;
            consumed = pkt_valid && !busy;
            @(posedge clock); #1;
            t++;
            if (consumed) cons++;
            if (stall > 0) stall--;
        end
        busy = 1'b0;
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, t);
        end
        @(negedge clock); #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_pkt_valid: got %b, required 0", pkt_valid); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
        checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL rst_data_in: got %h, required 00", data_in); end
        checks++; if (parity_out !== 8'h00) begin errors++; $display("FAIL rst_parity_out: got %h, required 00", parity_out); end
        checks++; if ({done, rej} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b, required 00", {done, rej}); end
        resetn = 1'b1;
        @(posedge clock); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_nominal;
        int base, pbase, pv0, d0;
        logic [7:0] par;
        fill_payload(14);
        build_model(14, 2, par);
        base = obs_n; pbase = par_n; pv0 = pv_cnt; d0 = done_cnt;
        drive_packet(14, 2, 0);
        checks++; if (obs[base] !== 8'h3A) begin errors++; $display("FAIL nom_header: got %h, required 3a", obs[base]); end
        checks++; if (obs_n - base !== 15) begin errors++; $display("FAIL nom_count: got %0d bytes, required 15", obs_n - base); end
        for (int i = 1; i <= 14; i++) begin
            checks++;
            if (obs[base+i] !== exp_b[i]) begin errors++; $display("FAIL nom_byte%0d: got %h, required %h", i, obs[base+i], exp_b[i]); end
        end
        checks++; if (pv_cnt - pv0 !== 15) begin errors++; $display("FAIL nom_pv_cycles: got %0d, required 15", pv_cnt - pv0); end
        checks++; if (par_obs[pbase] !== par) begin errors++; $display("FAIL nom_parity: got %h, required %h", par_obs[pbase], par); end
        checks++; if (parity_out !== par) begin errors++; $display("FAIL nom_parity_out: got %h, required %h", parity_out, par); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL nom_done: got %0d pulses, required 1", done_cnt - d0); end
        checks++; if (done_cyc - par_cyc !== 3) begin errors++; $display("FAIL nom_gap: done %0d cycles after parity, required 3", done_cyc - par_cyc); end
    endtask

    task automatic test_min;
        int base, pbase;
        logic [7:0] par;
        pay[0] = 8'hAA;
        build_model(1, 1, par);
        base = obs_n; pbase = par_n;
        drive_packet(1, 1, 0);
        checks++; if (obs[base] !== 8'h05) begin errors++; $display("FAIL min_header: got %h, required 05", obs[base]); end
        checks++; if (obs[base+1] !== 8'hAA) begin errors++; $display("FAIL min_payload: got %h, required aa", obs[base+1]); end
        checks++; if (par_obs[pbase] !== 8'hAF) begin errors++; $display("FAIL min_parity: got %h, required af", par_obs[pbase]); end
        checks++; if (parity_out !== par) begin errors++; $display("FAIL min_parity_out: got %h, required %h", parity_out, par); end
    endtask

    task automatic test_busy;
        int base, pbase, pv0, h0;
        logic [7:0] par;
        fill_payload(14);
        build_model(14, 2, par);
        base = obs_n; pbase = par_n; pv0 = pv_cnt; h0 = hold_err;
        drive_packet(14, 2, 1);
        checks++; if (obs_n - base !== 15) begin errors++; $display("FAIL busy_count: got %0d bytes, required 15", obs_n - base); end
        for (int i = 0; i <= 14; i++) begin
            checks++;
            if (obs[base+i] !== exp_b[i]) begin errors++; $display("FAIL busy_byte%0d: got %h, required %h", i, obs[base+i], exp_b[i]); end
        end
        checks++; if (pv_cnt - pv0 !== 18) begin errors++; $display("FAIL busy_pv_cycles: got %0d, required 18", pv_cnt - pv0); end
        checks++; if (hold_err - h0 !== 0) begin errors++; $display("FAIL busy_hold: %0d changes while stalled, required 0", hold_err - h0); end
        checks++; if (par_obs[pbase] !== par) begin errors++; $display("FAIL busy_parity: got %h, required %h", par_obs[pbase], par); end
    endtask

    task automatic test_illegal;
        int lens [2];
        int addrs [2];
        int r0, s0, p0;
        lens[0] = 5; addrs[0] = 3;
        lens[1] = 0; addrs[1] = 1;
        for (int k = 0; k < 2; k++) begin
            r0 = rej_cnt; s0 = sr_cnt; p0 = pv_cnt;
            drive_packet(lens[k], addrs[k], 0);
            checks++; if (rej !== 1'b1) begin errors++; $display("FAIL ill%0d_rej: got %b, required 1", k, rej); end
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ill%0d_cmd_ready: got %b, required 1", k, cmd_ready); end
            @(posedge clock); #1;
            checks++; if (rej !== 1'b0) begin errors++; $display("FAIL ill%0d_rej_pulse: got %b, required 0", k, rej); end
            repeat (3) @(posedge clock);
            #1;
            checks++; if (rej_cnt - r0 !== 1) begin errors++; $display("FAIL ill%0d_rej_count: got %0d, required 1", k, rej_cnt - r0); end
            checks++; if (sr_cnt - s0 !== 0) begin errors++; $display("FAIL ill%0d_s_ready: got %0d cycles, required 0", k, sr_cnt - s0); end
            checks++; if (pv_cnt - p0 !== 0) begin errors++; $display("FAIL ill%0d_pkt_valid: got %0d cycles, required 0", k, pv_cnt - p0); end
        end
    endtask

    task automatic test_max;
        int base, pbase, bad;
        logic [7:0] par;
        fill_payload(63);
        build_model(63, 0, par);
        base = obs_n; pbase = par_n; bad = 0;
        drive_packet(63, 0, 0);
        checks++; if (obs[base] !== 8'hFC) begin errors++; $display("FAIL max_header: got %h, required fc", obs[base]); end
        checks++; if (obs_n - base !== 64) begin errors++; $display("FAIL max_count: got %0d bytes, required 64", obs_n - base); end
        for (int i = 1; i <= 63; i++) if (obs[base+i] !== exp_b[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL max_payload: %0d wrong bytes, required 0", bad); end
        checks++; if (par_obs[pbase] !== par) begin errors++; $display("FAIL max_parity: got %h, required %h", par_obs[pbase], par); end
    endtask

    task automatic test_reset_mid;
        int d0, base, pbase, bad;
        logic [7:0] par;
        fill_payload(14);
        d0 = done_cnt;
        drive_packet(14, 1, 3);
        #1;
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL mid_pkt_valid: got %b, required 0", pkt_valid); end
        checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL mid_data_in: got %h, required 00", data_in); end
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: cmd_ready %b, required 1", cmd_ready); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_done: got %0d pulses, required 0", done_cnt - d0); end
        fill_payload(9);
        build_model(9, 1, par);
        base = obs_n; pbase = par_n; bad = 0;
        drive_packet(9, 1, 0);
        for (int i = 0; i <= 9; i++) if (obs[base+i] !== exp_b[i]) bad++;
        checks++; if (bad !== 0 || obs_n - base !== 10) begin errors++; $display("FAIL mid_clean_packet: %0d wrong of %0d bytes, required 0 of 10", bad, obs_n - base); end
        checks++; if (par_obs[pbase] !== par) begin errors++; $display("FAIL mid_clean_parity: got %h, required %h", par_obs[pbase], par); end
    endtask

    task automatic test_back_to_back;
        int base, pbase, bad;
        logic [7:0] par;
        fill_payload(6);
        build_model(6, 0, par);
        q_next = 1'b1; q_len = 3; q_addr = 2;
        base = obs_n; pbase = par_n; bad = 0;
        drive_packet(6, 0, 0);
        q_next = 1'b0;
        for (int i = 0; i <= 6; i++) if (obs[base+i] !== exp_b[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_first: %0d wrong bytes, required 0", bad); end
        checks++; if (par_obs[pbase] !== par) begin errors++; $display("FAIL b2b_first_parity: got %h, required %h", par_obs[pbase], par); end
        fill_payload(3);
        build_model(3, 2, par);
        base = obs_n; pbase = par_n; bad = 0;
        drive_packet(3, 2, 0);
        for (int i = 0; i <= 3; i++) if (obs[base+i] !== exp_b[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_second: %0d wrong bytes, required 0", bad); end
        checks++; if (last_gap < 3) begin errors++; $display("FAIL b2b_gap: %0d idle cycles, required >= 3", last_gap); end
    endtask

    task automatic test_random;
        int len, addr, base, pbase, bad;
        logic [7:0] par;
        for (int n = 0; n < 6; n++) begin
            len  = $urandom_range(1, 63);
            addr = $urandom_range(0, 2);
            fill_payload(len);
            build_model(len, addr, par);
            base = obs_n; pbase = par_n; bad = 0;
            drive_packet(len, addr, 2);
            for (int i = 0; i <= len; i++) if (obs[base+i] !== exp_b[i]) bad++;
            checks++; if (bad !== 0 || obs_n - base !== len + 1) begin errors++; $display("FAIL rnd%0d_stream: %0d wrong of %0d bytes, required 0 of %0d", n, bad, obs_n - base, len + 1); end
            checks++; if (par_obs[pbase] !== par || parity_out !== par) begin errors++; $display("FAIL rnd%0d_parity: got %h/%h, required %h", n, par_obs[pbase], parity_out, par); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_min();
        test_busy();
        test_illegal();
        test_max();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
